// File: rtl/mult_arbiter_if.sv
// Bus between the shared-multiplier arbiter, its two requesters and the multiplier.
//
// Issue handshake: a requester raises *_valid with operands held stable; the op
// transfers on the rising edge of any cycle where *_valid and *_ready are both 1.
// *_ready is never 1 without its *_valid, and at most one *_ready is 1 per cycle.
// Responses (*_resp_valid with resp_z) are one-cycle strobes with no backpressure.
interface mult_arbiter_if #(
    parameter int WIDTH = 4
);
    logic                 a_valid;
    logic                 a_ready;
    logic [WIDTH-1:0]     a_x;
    logic [WIDTH-1:0]     a_y;
    logic                 b_valid;
    logic                 b_ready;
    logic [WIDTH-1:0]     b_x;
    logic [WIDTH-1:0]     b_y;
    logic                 a_resp_valid;
    logic                 b_resp_valid;
    logic [2*WIDTH-1:0]   resp_z;
    logic [WIDTH-1:0]     mult_x;
    logic [WIDTH-1:0]     mult_y;
    logic [2*WIDTH-1:0]   mult_z;
    logic                 busy;
    logic [7:0]           issue_count;
    logic                 rr_last_dbg;   // last port granted: 0 = A, 1 = B

    // Arbiter side
    modport slave (
        input  a_valid, a_x, a_y, b_valid, b_x, b_y, mult_z,
        output a_ready, b_ready, a_resp_valid, b_resp_valid, resp_z,
               mult_x, mult_y, busy, issue_count, rr_last_dbg
    );

    // Requester / multiplier side
    modport master (
        output a_valid, a_x, a_y, b_valid, b_x, b_y, mult_z,
        input  a_ready, b_ready, a_resp_valid, b_resp_valid, resp_z,
               mult_x, mult_y, busy, issue_count, rr_last_dbg
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one registered multiplier between ports A and B.
// A tag pipe (valid + originating port) runs alongside the multiplier so every
// product is strobed back only to the port that issued it, LATENCY+1 cycles
// after the handshake. LATENCY must be in 1..8 to match the multiplier.
module mult_arbiter #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic          clock_100Mhz,
    input  logic          reset,
    mult_arbiter_if.slave bus
);
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e              rr_last_q, rr_last_d;
    logic [WIDTH-1:0]   mult_x_q, mult_x_d;
    logic [WIDTH-1:0]   mult_y_q, mult_y_d;
    logic [7:0]         issue_count_q, issue_count_d;
    logic [LATENCY:0]   tag_v_q, tag_v_d;   // stage valid bits, 0 = newest
    logic [LATENCY:0]   tag_p_q, tag_p_d;   // stage port bits, 1 = B
    logic               grant_a, grant_b;
    logic               issue;

    // Combinational grant: lone requester always wins, contention goes to the
    // port that was not granted last; held off entirely during reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = (rr_last_q == PORT_B);
                grant_b = (rr_last_q == PORT_A);
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    // Grants only assert with their valid, so a grant is a handshake.
    assign issue = grant_a | grant_b;

    // Next-state: capture operands and bump the counter on issue; tag pipe
    // shifts every cycle with a bubble inserted when nothing issues.
    always_comb begin
        rr_last_d     = rr_last_q;
        mult_x_d      = mult_x_q;
        mult_y_d      = mult_y_q;
        issue_count_d = issue_count_q;
        tag_v_d       = {tag_v_q[LATENCY-1:0], issue};
        tag_p_d       = {tag_p_q[LATENCY-1:0], grant_b};
        if (grant_a) begin
            rr_last_d = PORT_A;
            mult_x_d  = bus.a_x;
            mult_y_d  = bus.a_y;
        end else if (grant_b) begin
            rr_last_d = PORT_B;
            mult_x_d  = bus.b_x;
            mult_y_d  = bus.b_y;
        end
        if (issue) begin
            issue_count_d = issue_count_q + 8'd1;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            rr_last_q     <= PORT_B;
            mult_x_q      <= '0;
            mult_y_q      <= '0;
            issue_count_q <= '0;
            tag_v_q       <= '0;
            tag_p_q       <= '0;
        end else begin
            rr_last_q     <= rr_last_d;
            mult_x_q      <= mult_x_d;
            mult_y_q      <= mult_y_d;
            issue_count_q <= issue_count_d;
            tag_v_q       <= tag_v_d;
            tag_p_q       <= tag_p_d;
        end
    end

    assign bus.a_ready      = grant_a;
    assign bus.b_ready      = grant_b;
    assign bus.mult_x       = mult_x_q;
    assign bus.mult_y       = mult_y_q;
    assign bus.issue_count  = issue_count_q;
    assign bus.rr_last_dbg  = rr_last_q;
    assign bus.busy         = |tag_v_q;
    assign bus.resp_z       = bus.mult_z;
    assign bus.a_resp_valid = tag_v_q[LATENCY] & ~tag_p_q[LATENCY];
    assign bus.b_resp_valid = tag_v_q[LATENCY] &  tag_p_q[LATENCY];
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a two-stage multiplier model closes the loop, a
// negedge monitor models arbitration, counter and busy, and keeps per-port
// expected queues of (product, due cycle) popped when strobes appear.
module tb_mult_arbiter;
    localparam int W   = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mult_arbiter_if #(.WIDTH(W)) bus ();

    mult_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .bus          (bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered multiplier model, LAT edges from operands to product
    logic [2*W-1:0] z1 = '0;
    logic [2*W-1:0] z2 = '0;
    always @(posedge clk) begin
        z1 <= {4'b0, bus.mult_x} * {4'b0, bus.mult_y};
        z2 <= z1;
    end
    assign bus.mult_z = z2;

    // Scoreboard state
    logic [2*W-1:0] exp_a_q[$];
    logic [2*W-1:0] exp_b_q[$];
    int             exp_a_cyc_q[$];
    int             exp_b_cyc_q[$];
    logic           m_rr = 1'b1;
    logic [7:0]     m_cnt = 8'd0;
    int             a_seen = 0;
    int             b_seen = 0;

    // Monitor: model grant, counter, busy; push on handshake, pop on strobe
    always @(negedge clk) begin : mon
        logic           exp_ar, exp_br, exp_busy;
        logic [2*W-1:0] p, pa, pb;
        int             c;
        if (reset === 1'b1) begin
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.a_resp_valid !== 1'b0 ||
                bus.b_resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.issue_count !== 8'd0) begin
                failures++;
                $display("FAIL reset_outputs: ar=%b br=%b arv=%b brv=%b busy=%b cnt=%0d expected all 0",
                         bus.a_ready, bus.b_ready, bus.a_resp_valid, bus.b_resp_valid, bus.busy, bus.issue_count);
            end
            m_rr  = 1'b1;
            m_cnt = 8'd0;
            exp_a_q.delete(); exp_a_cyc_q.delete();
            exp_b_q.delete(); exp_b_cyc_q.delete();
        end else begin
            exp_busy = (exp_a_q.size() + exp_b_q.size()) != 0;
            exp_ar   = bus.a_valid && (!bus.b_valid || m_rr);
            exp_br   = bus.b_valid && (!bus.a_valid || !m_rr);
            checks++;
            if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br) begin
                failures++;
                $display("FAIL grant: cyc=%0d got a=%b b=%b expected a=%b b=%b",
                         cyc, bus.a_ready, bus.b_ready, exp_ar, exp_br);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                failures++;
                $display("FAIL busy: cyc=%0d got %b expected %b", cyc, bus.busy, exp_busy);
            end
            checks++;
            if (bus.issue_count !== m_cnt) begin
                failures++;
                $display("FAIL issue_count: cyc=%0d got %0d expected %0d", cyc, bus.issue_count, m_cnt);
            end
            // Port A responses
            if (bus.a_resp_valid === 1'b1) begin
                a_seen++;
                checks++;
                if (exp_a_q.size() == 0) begin
                    failures++;
                    $display("FAIL a_resp_unexpected: cyc=%0d got z=%0d expected no strobe", cyc, bus.resp_z);
                end else begin
                    p = exp_a_q.pop_front();
                    c = exp_a_cyc_q.pop_front();
                    if (bus.resp_z !== p || cyc != c) begin
                        failures++;
                        $display("FAIL a_resp: got z=%0d at cyc %0d expected z=%0d at cyc %0d", bus.resp_z, cyc, p, c);
                    end
                end
            end else if (exp_a_q.size() != 0 && exp_a_cyc_q[0] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL a_resp_missing: cyc=%0d got no strobe expected z=%0d", cyc, exp_a_q[0]);
                void'(exp_a_q.pop_front());
                void'(exp_a_cyc_q.pop_front());
            end
            // Port B responses
            if (bus.b_resp_valid === 1'b1) begin
                b_seen++;
                checks++;
                if (exp_b_q.size() == 0) begin
                    failures++;
                    $display("FAIL b_resp_unexpected: cyc=%0d got z=%0d expected no strobe", cyc, bus.resp_z);
                end else begin
                    p = exp_b_q.pop_front();
                    c = exp_b_cyc_q.pop_front();
                    if (bus.resp_z !== p || cyc != c) begin
                        failures++;
                        $display("FAIL b_resp: got z=%0d at cyc %0d expected z=%0d at cyc %0d", bus.resp_z, cyc, p, c);
                    end
                end
            end else if (exp_b_q.size() != 0 && exp_b_cyc_q[0] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL b_resp_missing: cyc=%0d got no strobe expected z=%0d", cyc, exp_b_q[0]);
                void'(exp_b_q.pop_front());
                void'(exp_b_cyc_q.pop_front());
            end
            // Record issues from the model's own grant decision
            pa = {4'b0, bus.a_x} * {4'b0, bus.a_y};
            pb = {4'b0, bus.b_x} * {4'b0, bus.b_y};
            if (exp_ar) begin
                exp_a_q.push_back(pa);
                exp_a_cyc_q.push_back(cyc + LAT + 1);
                m_rr  = 1'b0;
                m_cnt = m_cnt + 8'd1;
            end
            if (exp_br) begin
                exp_b_q.push_back(pb);
                exp_b_cyc_q.push_back(cyc + LAT + 1);
                m_rr  = 1'b1;
                m_cnt = m_cnt + 8'd1;
            end
        end
    end

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic drain();
        int n;
        idle_inputs();
        n = 0;
        while ((exp_a_q.size() + exp_b_q.size()) != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        checks++;
        if ((exp_a_q.size() + exp_b_q.size()) != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL drain: pending=%0d busy=%b expected 0 and 0",
                     exp_a_q.size() + exp_b_q.size(), bus.busy);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        reset = 1'b0;
        step();
        // Put something in flight so reset has visible effect
        bus.a_valid = 1'b1; bus.a_x = 4'd5; bus.a_y = 4'd5;
        step();
        #1;
        reset = 1'b1;          // mid-cycle, with A still requesting
        #1;
        checks++;
        if (bus.issue_count !== 8'd0 || bus.busy !== 1'b0 || bus.mult_x !== 4'd0 ||
            bus.mult_y !== 4'd0 || bus.a_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_immediate: cnt=%0d busy=%b mx=%0d my=%0d ar=%b expected all 0",
                     bus.issue_count, bus.busy, bus.mult_x, bus.mult_y, bus.a_ready);
        end
        checks++;
        if (bus.rr_last_dbg !== 1'b1) begin
            failures++;
            $display("FAIL reset_rr_last: got %b expected 1", bus.rr_last_dbg);
        end
        step();
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.a_resp_valid !== 1'b0 ||
                bus.b_resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL idle: i=%0d ar=%b br=%b arv=%b brv=%b busy=%b expected all 0",
                         i, bus.a_ready, bus.b_ready, bus.a_resp_valid, bus.b_resp_valid, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        int ic, a0, b0;
        do_reset();
        a0 = a_seen; b0 = b_seen;
        bus.a_valid = 1'b1; bus.a_x = 4'd7; bus.a_y = 4'd9;
        ic = cyc;
        step();
        idle_inputs();
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (bus.a_resp_valid !== (cyc == ic + LAT + 1) || bus.b_resp_valid !== 1'b0 ||
                (bus.a_resp_valid === 1'b1 && bus.resp_z !== 8'd63)) begin
                failures++;
                $display("FAIL single_resp: cyc=%0d arv=%b brv=%b z=%0d expected arv=%b z=63",
                         cyc, bus.a_resp_valid, bus.b_resp_valid, bus.resp_z, cyc == ic + LAT + 1);
            end
            step();
        end
        checks++;
        if (bus.issue_count !== 8'd1 || a_seen - a0 != 1 || b_seen != b0) begin
            failures++;
            $display("FAIL single_count: cnt=%0d a_resps=%0d b_resps=%0d expected 1 1 0",
                     bus.issue_count, a_seen - a0, b_seen - b0);
        end
    endtask

    task automatic test_contention();
        int a0, b0;
        do_reset();
        a0 = a_seen; b0 = b_seen;
        bus.a_valid = 1'b1; bus.a_x = 4'd15; bus.a_y = 4'd15;
        bus.b_valid = 1'b1; bus.b_x = 4'd3;  bus.b_y = 4'd4;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.a_ready !== (i % 2 == 0) || bus.b_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL contention_grant: i=%0d got a=%b b=%b expected a=%b b=%b",
                         i, bus.a_ready, bus.b_ready, i % 2 == 0, i % 2 == 1);
            end
            step();
        end
        drain();
        checks++;
        if (a_seen - a0 != 3 || b_seen - b0 != 3) begin
            failures++;
            $display("FAIL contention_resps: got a=%0d b=%0d expected a=3 b=3", a_seen - a0, b_seen - b0);
        end
    endtask

    task automatic test_drop();
        int a0, b0;
        logic [7:0] cnt0;
        a0 = a_seen; b0 = b_seen;
        cnt0 = bus.issue_count;
        // rr_last is B after the contention run, so A wins this one
        bus.a_valid = 1'b1; bus.a_x = 4'd2; bus.a_y = 4'd6;
        bus.b_valid = 1'b1; bus.b_x = 4'd9; bus.b_y = 4'd9;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_grant: got a=%b b=%b expected a=1 b=0", bus.a_ready, bus.b_ready);
        end
        step();
        drain();
        checks++;
        if (bus.issue_count !== cnt0 + 8'd1 || b_seen != b0 || a_seen - a0 != 1) begin
            failures++;
            $display("FAIL drop: cnt=%0d b_resps=%0d a_resps=%0d expected cnt=%0d b=0 a=1",
                     bus.issue_count, b_seen - b0, a_seen - a0, cnt0 + 8'd1);
        end
    endtask

    task automatic test_reset_midflight();
        int a0;
        do_reset();
        a0 = a_seen;
        bus.a_valid = 1'b1; bus.a_x = 4'd2; bus.a_y = 4'd3;
        step();
        step();
        idle_inputs();
        #1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (a_seen != a0 || bus.issue_count !== 8'd0 || bus.rr_last_dbg !== 1'b1) begin
            failures++;
            $display("FAIL midflight: a_resps=%0d cnt=%0d rr_last=%b expected 0 0 1",
                     a_seen - a0, bus.issue_count, bus.rr_last_dbg);
        end
    endtask

    task automatic test_wrap();
        int a0;
        do_reset();
        a0 = a_seen;
        bus.a_valid = 1'b1; bus.a_x = 4'd1; bus.a_y = 4'd1;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_busy: i=%0d got %b expected 1", i, bus.busy);
                end
            end
            if (i == 255) begin
                checks++;
                if (bus.issue_count !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_pre: got %0d expected 255", bus.issue_count);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.issue_count !== 8'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wrap: cnt=%0d busy=%b expected 0 1", bus.issue_count, bus.busy);
        end
        drain();
        checks++;
        if (a_seen - a0 != 256) begin
            failures++;
            $display("FAIL wrap_resps: got %0d expected 256", a_seen - a0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bus.a_valid = 1'($urandom_range(0, 1));
            bus.b_valid = 1'($urandom_range(0, 1));
            bus.a_x = 4'($urandom_range(0, 15));
            bus.a_y = 4'($urandom_range(0, 15));
            bus.b_x = 4'($urandom_range(0, 15));
            bus.b_y = 4'($urandom_range(0, 15));
            step();
        end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        bus.a_x = '0; bus.a_y = '0; bus.b_x = '0; bus.b_y = '0;
        test_reset();
        test_single();
        test_contention();
        test_drop();
        test_reset_midflight();
        test_wrap();
        test_random();
        checks++;
        if ((exp_a_q.size() + exp_b_q.size()) != 0) begin
            failures++;
            $display("FAIL leftover: got %0d pending expected 0", exp_a_q.size() + exp_b_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one registered 4x4 multiplier (`multiplier_DFF`) between two requesters (port A, port B) with round-robin arbitration, a valid/ready issue handshake and tag-routed, fixed-latency responses. It sits between the operand sources (switch capture logic, test sequencer) and the multiplier, whose product also feeds the seven-segment display path. It issues at most one operation per cycle and tracks every in-flight operation so each result returns only to its originator.

## Interface
- `WIDTH`, default 4: operand width; product is 2*WIDTH.
- `LATENCY`, default 2: edges from operands presented on `mult_x`/`mult_y` to a valid `mult_z` (matches `multiplier_DFF`); legal range 1..8.
- `clock_100Mhz`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`, `b_valid`  in  1 each  requester has an operation pending.
- `a_ready`, `b_ready`  out  1 each  grant; the op transfers on a cycle with valid&ready.
- `a_x`, `a_y`, `b_x`, `b_y`  in  WIDTH each  operands.
- `a_resp_valid`, `b_resp_valid`  out  1 each  one-cycle result strobe; no backpressure.
- `resp_z`  out  2*WIDTH  product, shared by both ports; qualified by the strobes.
- `mult_x`, `mult_y`  out  WIDTH each  registered operands to the multiplier.
- `mult_z`  in  2*WIDTH  multiplier product.
- `busy`  out  1  any operation in flight.
- `issue_count`  out  8  total operations issued, wraps 255->0.

## Operation
- Arbitration is combinational from the `*_valid` inputs and `rr_last` (1 bit, last port granted).
  - Only A valid: `a_ready`=1. Only B valid: `b_ready`=1. Neither valid: both 0.
  - Both valid: grant the port not equal to `rr_last`. `rr_last` resets to B, so A wins the first contention.
  - `a_ready` and `b_ready` are never both 1. `ready` never asserts without the matching `valid`.
- On a handshake edge, the arbiter:
  - loads `mult_x`/`mult_y` with the granted port's operands;
  - sets `rr_last` to the granted port;
  - increments `issue_count`;
  - loads tag pipe stage 0 with {valid=1, port}.
- With no handshake, `mult_x`/`mult_y` hold their last values and stage 0 loads valid=0.
- Tag pipe has stages 0..LATENCY and shifts every edge unconditionally.
- Responses are driven from the last stage:
  - `a_resp_valid` = stage[LATENCY].valid & port==A; `b_resp_valid` likewise for B.
  - `resp_z` = `mult_z`, passed through combinationally.
- `busy` = OR of all stage valid bits.
- Requesters may drop `valid` without a handshake. Operands are sampled only on the handshake edge.
- Products are unsigned: `resp_z` = x*y, maximum 15*15=225 for WIDTH=4.

## Timing
- Reset (asynchronous, any time): every output and register goes to 0, namely `mult_x`, `mult_y`, `issue_count`, all tag stages, `busy`, and both `*_resp_valid`. `rr_last` goes to B.
  - In-flight operations are discarded and no response is ever produced for them.
  - `*_ready` stays combinational but is gated 0 while `reset`=1.
- Latency: a handshake in cycle C gives its response strobe in cycle C+LATENCY+1 (C+3 at default).
- Throughput: one issue per cycle, sustained. Back-to-back issues return on consecutive cycles in issue order.
- Both ports valid continuously: grants alternate A,B,A,B… every cycle.
- A port held valid alone is granted every cycle. Its grant is unaffected by `rr_last`.
- `issue_count` at 255 plus one issue becomes 0.

## Test plan
- Reset then idle: assert `reset` mid-cycle. All outputs go to 0 immediately. With no valids for 10 cycles, no ready, no resp, and `busy`=0.
- Single op: A issues 7x9 in cycle 5. `a_resp_valid`=1 with `resp_z`=63 in cycle 8 only. `b_resp_valid` stays 0. `issue_count`=1.
- Contention: both valid continuously from cycle 0 for 6 cycles, A=15x15, B=3x4. Grants are A,B,A,B,A,B. Responses alternate 225 (A) and 12 (B) in cycles 3..8.
- Drop without handshake: B is valid for 1 cycle while A wins, then B deasserts. No B response follows. `issue_count` increments by 1 only.
- Reset mid-flight: A issues in cycles 0 and 1, and `reset` pulses in cycle 2. No `a_resp_valid` ever appears. After release, `rr_last`=B and `issue_count`=0.
- Counter wrap: 256 consecutive A issues of 1x1. `issue_count` returns to 0. All 256 responses are 1, with `busy` high throughout the stream.
